// File: rtl/mbist_mem_collar_if.sv
// Bundle of BIST, functional, SRAM and result-chain signals seen by one
// memory collar. The slave modport is the collar's view; master is the
// view of everything around it (controller, functional logic, SRAM).
interface mbist_mem_collar_if #(
    parameter int unsigned BG_DATA = 2,
    parameter int unsigned ADDR_X  = 2,
    parameter int unsigned ADDR_Y  = 2
);
    localparam int unsigned AW = ADDR_X + ADDR_Y;

    // controller side
    logic                i_mbist_run;
    logic [ADDR_X-1:0]   i_addr_x;
    logic [ADDR_Y-1:0]   i_addr_y;
    logic [BG_DATA-1:0]  i_data;
    logic                i_cs;
    logic                i_we;
    logic                i_re;
    logic                i_comp_en;
    logic                o_fail_flag;
    logic                i_shift_result;
    logic                si;
    logic                so;

    // functional side
    logic [AW-1:0]       func_addr;
    logic [BG_DATA-1:0]  func_wdata;
    logic                func_cs;
    logic                func_we;
    logic [BG_DATA-1:0]  func_rdata;

    // SRAM side
    logic [AW-1:0]       mem_addr;
    logic [BG_DATA-1:0]  mem_wdata;
    logic                mem_cs;
    logic                mem_we;
    logic [BG_DATA-1:0]  mem_rdata;

    modport slave (
        input  i_mbist_run, i_addr_x, i_addr_y, i_data,
        input  i_cs, i_we, i_re, i_comp_en,
        output o_fail_flag,
        input  i_shift_result, si,
        output so,
        input  func_addr, func_wdata, func_cs, func_we,
        output func_rdata,
        output mem_addr, mem_wdata, mem_cs, mem_we,
        input  mem_rdata
    );

    modport master (
        output i_mbist_run, i_addr_x, i_addr_y, i_data,
        output i_cs, i_we, i_re, i_comp_en,
        input  o_fail_flag,
        output i_shift_result, si,
        input  so,
        output func_addr, func_wdata, func_cs, func_we,
        input  func_rdata,
        input  mem_addr, mem_wdata, mem_cs, mem_we,
        output mem_rdata
    );
endinterface

// File: rtl/mbist_mem_collar.sv
// Memory-side BIST collar: steers BIST or functional traffic into one SRAM,
// compares BIST reads against the expected background after the SRAM read
// latency, and accumulates fails into a serially unloadable result register
// {fail_sticky, fail_cnt, first_addr{y,x}, first_xor}.
module mbist_mem_collar #(
    parameter int unsigned BG_DATA    = 2,
    parameter int unsigned ADDR_X     = 2,
    parameter int unsigned ADDR_Y     = 2,
    parameter int unsigned RD_LAT     = 1,
    parameter int unsigned FAIL_CNT_W = 4
) (
    input logic               clk,
    input logic               rst,
    mbist_mem_collar_if.slave mif
);
    localparam int unsigned AW      = ADDR_X + ADDR_Y;
    localparam int unsigned RES_W   = 1 + FAIL_CNT_W + AW + BG_DATA;
    localparam int unsigned ADDR_LO = BG_DATA;
    localparam int unsigned CNT_LO  = BG_DATA + AW;
    localparam int unsigned STICKY  = RES_W - 1;

    logic                  run_q;
    logic                  run_rise;
    logic                  launch;
    logic                  mature;
    logic                  mismatch;
    logic [BG_DATA-1:0]    cmp_xor;
    logic [RD_LAT-1:0]     pipe_vld;
    logic [AW-1:0]         pipe_addr [RD_LAT];
    logic [BG_DATA-1:0]    pipe_data [RD_LAT];
    logic [RES_W-1:0]      res;
    logic [FAIL_CNT_W-1:0] fail_cnt;

    // SRAM port steering: BIST during a run, functional otherwise; strobes held off in reset
    always_comb begin
        mif.mem_addr  = mif.func_addr;
        mif.mem_wdata = mif.func_wdata;
        mif.mem_cs    = mif.func_cs;
        mif.mem_we    = mif.func_we;
        if (mif.i_mbist_run) begin
            mif.mem_addr  = {mif.i_addr_y, mif.i_addr_x};
            mif.mem_wdata = mif.i_data;
            mif.mem_cs    = mif.i_cs;
            mif.mem_we    = mif.i_we;
        end
        if (rst) begin
            mif.mem_cs = 1'b0;
            mif.mem_we = 1'b0;
        end
    end

    assign mif.func_rdata = mif.mem_rdata;

    assign run_rise = mif.i_mbist_run & ~run_q;
    assign launch   = mif.i_mbist_run & mif.i_cs & mif.i_re & ~mif.i_we & mif.i_comp_en;
    assign mature   = pipe_vld[RD_LAT-1];
    assign cmp_xor  = pipe_data[RD_LAT-1] ^ mif.mem_rdata;
    assign mismatch = mature & (|cmp_xor);
    assign fail_cnt = res[CNT_LO +: FAIL_CNT_W];

    // Registered copy of the run indicator for start-of-run detection
    always_ff @(posedge clk) begin
        if (rst) run_q <= 1'b0;
        else     run_q <= mif.i_mbist_run;
    end

    // Token valids: a run start flushes tokens in flight but keeps this cycle's launch
    always_ff @(posedge clk) begin
        if (rst) begin
            pipe_vld <= '0;
        end else begin
            pipe_vld[0] <= launch;
            for (int unsigned i = 1; i < RD_LAT; i++)
                pipe_vld[i] <= run_rise ? 1'b0 : pipe_vld[i-1];
        end
    end

    // Token address and expected data travel alongside the valids
    always_ff @(posedge clk) begin
        pipe_addr[0] <= {mif.i_addr_y, mif.i_addr_x};
        pipe_data[0] <= mif.i_data;
        for (int unsigned i = 1; i < RD_LAT; i++) begin
            pipe_addr[i] <= pipe_addr[i-1];
            pipe_data[i] <= pipe_data[i-1];
        end
    end

    // Result register: reset > run-start clear > shift > compare update
    always_ff @(posedge clk) begin
        if (rst) begin
            res <= '0;
        end else if (run_rise) begin
            res <= '0;
        end else if (mif.i_shift_result) begin
            res <= {mif.si, res[RES_W-1:1]};
        end else if (mismatch) begin
            res[STICKY] <= 1'b1;
            if (fail_cnt != '1)
                res[CNT_LO +: FAIL_CNT_W] <= fail_cnt + 1'b1;
            if (!res[STICKY]) begin
                res[ADDR_LO +: AW] <= pipe_addr[RD_LAT-1];
                res[0 +: BG_DATA]  <= cmp_xor;
            end
        end
    end

    assign mif.o_fail_flag = res[STICKY];
    assign mif.so          = res[0];
endmodule

// File: tb/tb_mbist_mem_collar.sv
// Scoreboard bench for mbist_mem_collar: one collar with a 1-cycle SRAM and
// one with a 3-cycle SRAM. Stimulus queues hand-computed expectations tagged
// with the current cycle; a negedge monitor pops and compares them.
module tb_mbist_mem_collar;
  localparam int SO_A = 0, FLAG_A = 1, CS_A = 2, WE_A = 3, ADDR_A = 4,
                 WDATA_A = 5, FRDATA_A = 6, SO_B = 7, FLAG_B = 8, CS_B = 9;

  typedef struct {
    string       name;
    int unsigned cyc;
    int          sig;
    logic [15:0] want;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  int unsigned cyc_cnt = 0;
  int          checks = 0;
  int          errors = 0;
  exp_t        sbq[$];

  always #5 clk = ~clk;

  mbist_mem_collar_if #(.BG_DATA(2), .ADDR_X(2), .ADDR_Y(2)) ifa ();
  mbist_mem_collar_if #(.BG_DATA(2), .ADDR_X(2), .ADDR_Y(2)) ifb ();

  mbist_mem_collar #(.BG_DATA(2), .ADDR_X(2), .ADDR_Y(2), .RD_LAT(1), .FAIL_CNT_W(4))
    dut_a (.clk(clk), .rst(rst), .mif(ifa));
  mbist_mem_collar #(.BG_DATA(2), .ADDR_X(2), .ADDR_Y(2), .RD_LAT(3), .FAIL_CNT_W(4))
    dut_b (.clk(clk), .rst(rst), .mif(ifb));

  // SRAM A: 1-cycle read latency, optional bit0 stuck-at-0
  logic [1:0] mem_a [16];
  logic [1:0] rd_a;
  logic       stuck0 = 1'b0;
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 16; i++) mem_a[i] <= 2'b00;
    end else if (ifa.mem_cs && ifa.mem_we) begin
      mem_a[ifa.mem_addr] <= ifa.mem_wdata;
    end
    rd_a <= mem_a[ifa.mem_addr];
  end
  assign ifa.mem_rdata = stuck0 ? {rd_a[1], 1'b0} : rd_a;

  // SRAM B: 3-cycle read latency, holds 2'b01 everywhere except a bad cell at 4'hA
  logic [1:0] mem_b [16];
  logic [1:0] rb [3];
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 16; i++) mem_b[i] <= (i == 10) ? 2'b11 : 2'b01;
    end
    rb[0] <= mem_b[ifb.mem_addr];
    rb[1] <= rb[0];
    rb[2] <= rb[1];
  end
  assign ifb.mem_rdata = rb[2];

  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  function automatic logic [15:0] actual(input int sig);
    case (sig)
      SO_A:     return 16'(ifa.so);
      FLAG_A:   return 16'(ifa.o_fail_flag);
      CS_A:     return 16'(ifa.mem_cs);
      WE_A:     return 16'(ifa.mem_we);
      ADDR_A:   return 16'(ifa.mem_addr);
      WDATA_A:  return 16'(ifa.mem_wdata);
      FRDATA_A: return 16'(ifa.func_rdata);
      SO_B:     return 16'(ifb.so);
      FLAG_B:   return 16'(ifb.o_fail_flag);
      CS_B:     return 16'(ifb.mem_cs);
      default:  return 16'hFFFF;
    endcase
  endfunction

  // Monitor: compare every expectation due in the current cycle
  always @(negedge clk) begin
    exp_t        e;
    logic [15:0] act;
    while (sbq.size() > 0 && sbq[0].cyc <= cyc_cnt) begin
      e   = sbq.pop_front();
      act = actual(e.sig);
      checks++;
      if (act !== e.want) begin
        errors++;
        $display("FAIL %s: actual=%0h required=%0h (cycle %0d)",
                 e.name, act, e.want, cyc_cnt);
      end
    end
  end

  task automatic expect_now(input string name, input int sig, input logic [15:0] want);
    exp_t e;
    e.name = name;
    e.cyc  = cyc_cnt;
    e.sig  = sig;
    e.want = want;
    sbq.push_back(e);
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(input bit b, input logic run, input logic cs, input logic we,
                        input logic re, input logic comp, input logic [3:0] a,
                        input logic [1:0] d);
    if (!b) begin
      ifa.i_mbist_run = run; ifa.i_cs = cs; ifa.i_we = we; ifa.i_re = re;
      ifa.i_comp_en = comp; ifa.i_addr_x = a[1:0]; ifa.i_addr_y = a[3:2];
      ifa.i_data = d;
    end else begin
      ifb.i_mbist_run = run; ifb.i_cs = cs; ifb.i_we = we; ifb.i_re = re;
      ifb.i_comp_en = comp; ifb.i_addr_x = a[1:0]; ifb.i_addr_y = a[3:2];
      ifb.i_data = d;
    end
  endtask

  task automatic shift_out(input bit b, input logic [10:0] res);
    for (int i = 0; i < 11; i++) begin
      if (!b) begin ifa.i_shift_result = 1'b1; ifa.si = 1'b0; end
      else    begin ifb.i_shift_result = 1'b1; ifb.si = 1'b0; end
      expect_now($sformatf("so_%s[%0d]", b ? "b" : "a", i), b ? SO_B : SO_A, 16'(res[i]));
      cyc();
    end
    if (!b) ifa.i_shift_result = 1'b0;
    else    ifb.i_shift_result = 1'b0;
    expect_now(b ? "post_shift_flag_b" : "post_shift_flag_a", b ? FLAG_B : FLAG_A, 16'h0);
    expect_now(b ? "post_shift_so_b" : "post_shift_so_a", b ? SO_B : SO_A, 16'h0);
    cyc();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    set_op(0, 0, 0, 0, 0, 0, 4'h0, 2'b00);
    set_op(1, 0, 0, 0, 0, 0, 4'h0, 2'b00);
    ifa.i_shift_result = 1'b0; ifa.si = 1'b0;
    ifb.i_shift_result = 1'b0; ifb.si = 1'b0;
    ifa.func_addr = 4'h0; ifa.func_wdata = 2'b00; ifa.func_cs = 1'b1; ifa.func_we = 1'b1;
    ifb.func_addr = 4'h0; ifb.func_wdata = 2'b00; ifb.func_cs = 1'b0; ifb.func_we = 1'b0;

    // reset: outputs quiet, SRAM strobes forced low even with func_cs/func_we high
    cyc(); cyc();
    expect_now("rst_flag_a", FLAG_A, 16'h0);
    expect_now("rst_so_a",   SO_A,   16'h0);
    expect_now("rst_cs_a",   CS_A,   16'h0);
    expect_now("rst_we_a",   WE_A,   16'h0);
    expect_now("rst_flag_b", FLAG_B, 16'h0);
    expect_now("rst_so_b",   SO_B,   16'h0);
    cyc();
    rst = 1'b0;

    // functional path: mem_* follow func_*, BIST strobes ignored without run
    ifa.func_addr = 4'd5; ifa.func_wdata = 2'b10;
    set_op(0, 0, 1, 0, 1, 1, 4'h0, 2'b11);
    expect_now("func_addr",  ADDR_A,  16'h5);
    expect_now("func_wdata", WDATA_A, 16'h2);
    expect_now("func_cs",    CS_A,    16'h1);
    expect_now("func_we",    WE_A,    16'h1);
    cyc();
    ifa.func_we = 1'b0;
    expect_now("func_rd_we", WE_A, 16'h0);
    cyc();
    expect_now("func_rdata",     FRDATA_A, 16'h2);
    expect_now("func_no_launch", FLAG_A,   16'h0);
    cyc();
    expect_now("func_no_launch2", FLAG_A, 16'h0);
    ifa.func_cs = 1'b0;
    set_op(0, 0, 0, 0, 0, 0, 4'h0, 2'b00);
    cyc();

    // good memory: write 01 everywhere, read back with compare
    for (int a = 0; a < 16; a++) begin
      set_op(0, 1, 1, 1, 0, 0, 4'(a), 2'b01);
      if (a == 3) begin
        expect_now("bist_addr", ADDR_A, 16'h3);
        expect_now("bist_we",   WE_A,   16'h1);
        expect_now("bist_cs",   CS_A,   16'h1);
      end
      cyc();
    end
    for (int a = 0; a < 16; a++) begin
      set_op(0, 1, 1, 0, 1, 1, 4'(a), 2'b01);
      expect_now($sformatf("good_flag[%0d]", a), FLAG_A, 16'h0);
      cyc();
    end
    set_op(0, 0, 0, 0, 0, 0, 4'h0, 2'b00);
    expect_now("good_flag_tail0", FLAG_A, 16'h0);
    cyc();
    expect_now("good_flag_tail1", FLAG_A, 16'h0);
    cyc();
    shift_out(0, 11'h000);

    // bit0 stuck-0: every read fails, counter saturates, first fail at addr 0
    stuck0 = 1'b1;
    for (int a = 0; a < 16; a++) begin
      set_op(0, 1, 1, 0, 1, 1, 4'(a), 2'b01);
      if (a == 1) expect_now("stuck_flag_pre",  FLAG_A, 16'h0);
      if (a == 2) expect_now("stuck_flag_post", FLAG_A, 16'h1);
      cyc();
    end
    set_op(0, 0, 0, 0, 0, 0, 4'h0, 2'b00);
    cyc(); cyc();
    shift_out(0, 11'h7C1);

    // second run start after a failing run clears RES
    set_op(0, 1, 1, 0, 1, 1, 4'h3, 2'b01);
    cyc();
    set_op(0, 1, 0, 0, 0, 0, 4'h0, 2'b00);
    cyc();
    expect_now("rerun_fail_seen", FLAG_A, 16'h1);
    cyc();
    set_op(0, 0, 0, 0, 0, 0, 4'h0, 2'b00);
    expect_now("rerun_fail_held", FLAG_A, 16'h1);
    cyc();
    set_op(0, 1, 0, 0, 0, 0, 4'h0, 2'b00);
    expect_now("rerun_edge_flag", FLAG_A, 16'h1);
    cyc();
    expect_now("rerun_cleared", FLAG_A, 16'h0);
    set_op(0, 0, 0, 0, 0, 0, 4'h0, 2'b00);
    cyc();
    shift_out(0, 11'h000);
    stuck0 = 1'b0;

    // RD_LAT=3: back-to-back reads 3, A(bad), 4; compare lands 3 cycles after launch
    set_op(1, 1, 1, 0, 1, 1, 4'h3, 2'b01);
    cyc();
    set_op(1, 1, 1, 0, 1, 1, 4'hA, 2'b01);
    cyc();
    set_op(1, 1, 1, 0, 1, 1, 4'h4, 2'b01);
    cyc();
    set_op(1, 1, 0, 0, 0, 0, 4'h0, 2'b00);
    expect_now("lat3_flag_t3", FLAG_B, 16'h0);
    cyc();
    expect_now("lat3_flag_t4", FLAG_B, 16'h0);
    cyc();
    expect_now("lat3_flag_t5", FLAG_B, 16'h1);
    cyc();
    set_op(1, 0, 0, 0, 0, 0, 4'h0, 2'b00);
    cyc(); cyc();
    shift_out(1, 11'h46A);

    // reset mid-run with two bad-read tokens in flight
    set_op(1, 1, 1, 0, 1, 1, 4'hA, 2'b01);
    cyc();
    cyc();
    rst = 1'b1;
    expect_now("midrst_cs_b", CS_B, 16'h0);
    cyc();
    rst = 1'b0;
    set_op(1, 1, 0, 0, 0, 0, 4'h0, 2'b00);
    for (int k = 0; k < 5; k++) begin
      expect_now($sformatf("midrst_flag[%0d]", k), FLAG_B, 16'h0);
      expect_now($sformatf("midrst_so[%0d]", k),   SO_B,   16'h0);
      cyc();
    end
    set_op(1, 0, 0, 0, 0, 0, 4'h0, 2'b00);
    cyc();
    shift_out(1, 11'h000);

    cyc(); cyc();
    checks++;
    if (ifa.o_fail_flag !== 1'b0) begin
      errors++;
      $display("FAIL final_flag_a: actual=%0h required=0", ifa.o_fail_flag);
    end
    checks++;
    if (ifb.o_fail_flag !== 1'b0) begin
      errors++;
      $display("FAIL final_flag_b: actual=%0h required=0", ifb.o_fail_flag);
    end
    checks++;
    if (ifb.so !== 1'b0) begin
      errors++;
      $display("FAIL final_so_b: actual=%0h required=0", ifb.so);
    end
    checks++;
    if (ifa.mem_cs !== 1'b0) begin
      errors++;
      $display("FAIL final_cs_a: actual=%0h required=0", ifa.mem_cs);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
